// File: rtl/ga_coproc_sequencer_if.sv
// Request, datapath and writeback signals between the core, the GA sequencer and the GA datapath.
// The sequencer takes the slave view; the core/datapath side (or a bench) takes the master view.
interface ga_coproc_sequencer_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic [4:0]  req_rd_i;

    logic        dp_start_o;
    logic [2:0]  dp_op_o;
    logic [31:0] dp_a_o;
    logic [31:0] dp_b_o;
    logic        dp_done_i;
    logic [31:0] dp_result_i;
    logic        dp_abort_o;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [4:0]  rsp_rd_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;

    logic        flush_i;
    logic        busy_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, req_rd_i,
        input  dp_done_i, dp_result_i, rsp_ready_i, flush_i,
        output req_ready_o, dp_start_o, dp_op_o, dp_a_o, dp_b_o, dp_abort_o,
        output rsp_valid_o, rsp_rd_o, rsp_data_o, rsp_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, req_rd_i,
        output dp_done_i, dp_result_i, rsp_ready_i, flush_i,
        input  req_ready_o, dp_start_o, dp_op_o, dp_a_o, dp_b_o, dp_abort_o,
        input  rsp_valid_o, rsp_rd_o, rsp_data_o, rsp_err_o, busy_o
    );
endinterface

// File: rtl/ga_coproc_sequencer.sv
// Sequencer for a single in-flight GA coprocessor instruction: accepts a request, starts the
// datapath, waits for completion or timeout, and holds the writeback until the core takes it.
module ga_coproc_sequencer #(
    parameter int unsigned TimeoutCycles = 64,
    parameter logic [2:0]  IllegalOp     = 3'b111
) (
    input logic               clk_i,
    input logic               rst_i,
    ga_coproc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [15:0] TimerLast = 16'(TimeoutCycles - 1);

    state_t      state;
    logic [15:0] timer;
    logic        dp_start;
    logic        dp_abort;
    logic        rsp_valid;
    logic        rsp_err;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;
    logic [31:0] rsp_data;
    logic        req_ready;
    logic        accept;

    // Ready is held low while reset is applied so nothing is taken before the state is known.
    assign req_ready = (state == IDLE) && !bus.flush_i && !rst_i;
    assign accept    = bus.req_valid_i && req_ready;

    // Flush overrides every other transition; only an op that reached the datapath gets an abort.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            timer     <= '0;
            dp_start  <= 1'b0;
            dp_abort  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            rsp_data  <= '0;
        end else begin
            dp_start <= 1'b0;
            dp_abort <= 1'b0;
            if (bus.flush_i) begin
                if (state == ISSUE || state == WAIT) begin
                    dp_abort <= 1'b1;
                end
                rsp_valid <= 1'b0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            op_q     <= bus.req_op_i;
                            a_q      <= bus.req_a_i;
                            b_q      <= bus.req_b_i;
                            rd_q     <= bus.req_rd_i;
                            rsp_data <= '0;
                            if (bus.req_op_i == IllegalOp) begin
                                rsp_err   <= 1'b1;
                                rsp_valid <= 1'b1;
                                state     <= RESP;
                            end else begin
                                rsp_err  <= 1'b0;
                                dp_start <= 1'b1;
                                state    <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        timer <= '0;
                        state <= WAIT;
                    end
                    WAIT: begin
                        // Completion in the expiry cycle counts as a normal finish.
                        if (bus.dp_done_i) begin
                            rsp_data  <= bus.dp_result_i;
                            rsp_err   <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (timer == TimerLast) begin
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                            dp_abort  <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    RESP: begin
                        if (bus.rsp_ready_i) begin
                            rsp_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.dp_start_o  = dp_start;
    assign bus.dp_op_o     = op_q;
    assign bus.dp_a_o      = a_q;
    assign bus.dp_b_o      = b_q;
    assign bus.dp_abort_o  = dp_abort;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rd_o    = rd_q;
    assign bus.rsp_data_o  = rsp_data;
    assign bus.rsp_err_o   = rsp_err;
    assign bus.busy_o      = (state != IDLE);

endmodule

// File: tb/tb_ga_coproc_sequencer.sv
// Directed bench for ga_coproc_sequencer with TimeoutCycles=8; inputs are driven and outputs
// sampled a couple of time units after each rising edge.
module tb_ga_coproc_sequencer;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ga_coproc_sequencer_if bus ();

    ga_coproc_sequencer #(
        .TimeoutCycles(8),
        .IllegalOp(3'b111)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_a_i     = a;
        bus.req_b_i     = b;
        bus.req_rd_i    = rd;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++; if (bus.req_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%0b exp=0", bus.req_ready_o); end
        checks++; if ({bus.busy_o, bus.dp_start_o, bus.dp_abort_o, bus.rsp_valid_o, bus.rsp_err_o} !== 5'b0) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=00000", {bus.busy_o, bus.dp_start_o, bus.dp_abort_o, bus.rsp_valid_o, bus.rsp_err_o}); end
        checks++; if ({bus.dp_op_o, bus.dp_a_o, bus.dp_b_o, bus.rsp_rd_o, bus.rsp_data_o} !== 104'd0) begin failures++; $display("[TB] FAIL reset_regs got=%h exp=0", {bus.dp_op_o, bus.dp_a_o, bus.dp_b_o, bus.rsp_rd_o, bus.rsp_data_o}); end
        rst_i = 1'b0;
        #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got=%0b exp=1", bus.req_ready_o); end
    endtask

    task automatic test_normal();
        drive_req(3'b001, 32'h3, 32'h5, 5'd10);
        #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL normal_ready got=%0b exp=1", bus.req_ready_o); end
        tick();
        bus.req_valid_i = 1'b0;
        checks++; if (bus.dp_start_o !== 1'b1) begin failures++; $display("[TB] FAIL normal_start got=%0b exp=1", bus.dp_start_o); end
        checks++; if ({bus.dp_op_o, bus.dp_a_o, bus.dp_b_o} !== {3'd1, 32'd3, 32'd5}) begin failures++; $display("[TB] FAIL normal_operands got=%h exp=%h", {bus.dp_op_o, bus.dp_a_o, bus.dp_b_o}, {3'd1, 32'd3, 32'd5}); end
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("[TB] FAIL normal_busy got=%0b exp=1", bus.busy_o); end
        tick();
        checks++; if (bus.dp_start_o !== 1'b0) begin failures++; $display("[TB] FAIL normal_start_one_cycle got=%0b exp=0", bus.dp_start_o); end
        tick();
        tick();
        tick();
        bus.dp_done_i   = 1'b1;
        bus.dp_result_i = 32'hF;
        checks++; if (bus.rsp_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL normal_early_valid got=%0b exp=0", bus.rsp_valid_o); end
        tick();
        bus.dp_done_i   = 1'b0;
        bus.dp_result_i = 32'h0;
        checks++; if (bus.rsp_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL normal_valid got=%0b exp=1", bus.rsp_valid_o); end
        checks++; if ({bus.rsp_rd_o, bus.rsp_data_o, bus.rsp_err_o, bus.dp_abort_o} !== {5'd10, 32'hF, 1'b0, 1'b0}) begin failures++; $display("[TB] FAIL normal_rsp got=%h exp=%h", {bus.rsp_rd_o, bus.rsp_data_o, bus.rsp_err_o, bus.dp_abort_o}, {5'd10, 32'hF, 1'b0, 1'b0}); end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        #1;
        checks++; if ({bus.rsp_valid_o, bus.busy_o, bus.req_ready_o} !== 3'b001) begin failures++; $display("[TB] FAIL normal_idle got=%b exp=001", {bus.rsp_valid_o, bus.busy_o, bus.req_ready_o}); end
    endtask

    task automatic test_backpressure();
        drive_req(3'b010, 32'h7, 32'h9, 5'd4);
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        bus.dp_done_i   = 1'b1;
        bus.dp_result_i = 32'hABCD;
        tick();
        for (int i = 0; i < 5; i++) begin
            drive_req(3'b001, 32'h1, 32'h1, 5'd9);
            bus.dp_done_i   = 1'b1;
            bus.dp_result_i = 32'h5555;
            #1;
            checks++; if ({bus.rsp_valid_o, bus.rsp_rd_o, bus.rsp_data_o, bus.rsp_err_o} !== {1'b1, 5'd4, 32'hABCD, 1'b0}) begin failures++; $display("[TB] FAIL bp_hold[%0d] got=%h exp=%h", i, {bus.rsp_valid_o, bus.rsp_rd_o, bus.rsp_data_o, bus.rsp_err_o}, {1'b1, 5'd4, 32'hABCD, 1'b0}); end
            checks++; if ({bus.req_ready_o, bus.busy_o} !== 2'b01) begin failures++; $display("[TB] FAIL bp_ready_busy[%0d] got=%b exp=01", i, {bus.req_ready_o, bus.busy_o}); end
            tick();
        end
        bus.req_valid_i = 1'b0;
        bus.dp_done_i   = 1'b0;
        bus.rsp_ready_i = 1'b1;
        checks++; if (bus.rsp_data_o !== 32'hABCD) begin failures++; $display("[TB] FAIL bp_final_data got=%h exp=0000abcd", bus.rsp_data_o); end
        tick();
        bus.rsp_ready_i = 1'b0;
        checks++; if ({bus.rsp_valid_o, bus.busy_o} !== 2'b00) begin failures++; $display("[TB] FAIL bp_release got=%b exp=00", {bus.rsp_valid_o, bus.busy_o}); end
        bus.dp_done_i   = 1'b1;
        bus.dp_result_i = 32'hDEAD;
        tick();
        bus.dp_done_i   = 1'b0;
        checks++; if ({bus.rsp_valid_o, bus.busy_o} !== 2'b00) begin failures++; $display("[TB] FAIL idle_done_ignored got=%b exp=00", {bus.rsp_valid_o, bus.busy_o}); end
    endtask

    task automatic test_timeout();
        drive_req(3'b011, 32'h1, 32'h2, 5'd5);
        tick();
        bus.req_valid_i = 1'b0;
        checks++; if (bus.dp_start_o !== 1'b1) begin failures++; $display("[TB] FAIL to_start got=%0b exp=1", bus.dp_start_o); end
        repeat (8) tick();
        checks++; if ({bus.rsp_valid_o, bus.dp_abort_o, bus.busy_o} !== 3'b001) begin failures++; $display("[TB] FAIL to_before_expiry got=%b exp=001", {bus.rsp_valid_o, bus.dp_abort_o, bus.busy_o}); end
        tick();
        checks++; if (bus.dp_abort_o !== 1'b1) begin failures++; $display("[TB] FAIL to_abort got=%0b exp=1", bus.dp_abort_o); end
        checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o, bus.rsp_rd_o} !== {1'b1, 1'b1, 32'h0, 5'd5}) begin failures++; $display("[TB] FAIL to_rsp got=%h exp=%h", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o, bus.rsp_rd_o}, {1'b1, 1'b1, 32'h0, 5'd5}); end
        tick();
        checks++; if ({bus.dp_abort_o, bus.rsp_valid_o} !== 2'b01) begin failures++; $display("[TB] FAIL to_abort_one_cycle got=%b exp=01", {bus.dp_abort_o, bus.rsp_valid_o}); end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL to_release got=%0b exp=0", bus.busy_o); end
    endtask

    task automatic test_done_at_limit();
        drive_req(3'b100, 32'h8, 32'h9, 5'd6);
        tick();
        bus.req_valid_i = 1'b0;
        repeat (8) tick();
        bus.dp_done_i   = 1'b1;
        bus.dp_result_i = 32'h1234;
        tick();
        bus.dp_done_i   = 1'b0;
        checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.dp_abort_o, bus.rsp_data_o} !== {1'b1, 1'b0, 1'b0, 32'h1234}) begin failures++; $display("[TB] FAIL limit_done_wins got=%h exp=%h", {bus.rsp_valid_o, bus.rsp_err_o, bus.dp_abort_o, bus.rsp_data_o}, {1'b1, 1'b0, 1'b0, 32'h1234}); end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_illegal();
        drive_req(3'b111, 32'hFFFF, 32'h1, 5'd3);
        tick();
        bus.req_valid_i = 1'b0;
        checks++; if (bus.dp_start_o !== 1'b0) begin failures++; $display("[TB] FAIL illegal_no_start got=%0b exp=0", bus.dp_start_o); end
        checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rd_o, bus.rsp_data_o, bus.busy_o} !== {1'b1, 1'b1, 5'd3, 32'h0, 1'b1}) begin failures++; $display("[TB] FAIL illegal_rsp got=%h exp=%h", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rd_o, bus.rsp_data_o, bus.busy_o}, {1'b1, 1'b1, 5'd3, 32'h0, 1'b1}); end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL illegal_release got=%0b exp=0", bus.busy_o); end
    endtask

    task automatic test_flush();
        bus.flush_i = 1'b1;
        drive_req(3'b001, 32'h1, 32'h1, 5'd1);
        #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle_ready got=%0b exp=0", bus.req_ready_o); end
        tick();
        bus.flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        checks++; if ({bus.busy_o, bus.dp_start_o, bus.dp_abort_o} !== 3'b000) begin failures++; $display("[TB] FAIL flush_idle_no_accept got=%b exp=000", {bus.busy_o, bus.dp_start_o, bus.dp_abort_o}); end

        drive_req(3'b001, 32'h2, 32'h3, 5'd2);
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        bus.flush_i     = 1'b1;
        bus.dp_done_i   = 1'b1;
        bus.dp_result_i = 32'h77;
        tick();
        bus.flush_i   = 1'b0;
        bus.dp_done_i = 1'b0;
        checks++; if ({bus.dp_abort_o, bus.busy_o, bus.rsp_valid_o} !== 3'b100) begin failures++; $display("[TB] FAIL flush_wait got=%b exp=100", {bus.dp_abort_o, bus.busy_o, bus.rsp_valid_o}); end
        tick();
        checks++; if ({bus.dp_abort_o, bus.rsp_valid_o} !== 2'b00) begin failures++; $display("[TB] FAIL flush_wait_after got=%b exp=00", {bus.dp_abort_o, bus.rsp_valid_o}); end

        drive_req(3'b111, 32'h0, 32'h0, 5'd6);
        tick();
        bus.req_valid_i = 1'b0;
        checks++; if (bus.rsp_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL flush_resp_setup got=%0b exp=1", bus.rsp_valid_o); end
        bus.flush_i     = 1'b1;
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.flush_i     = 1'b0;
        bus.rsp_ready_i = 1'b0;
        checks++; if ({bus.rsp_valid_o, bus.dp_abort_o, bus.busy_o} !== 3'b000) begin failures++; $display("[TB] FAIL flush_resp got=%b exp=000", {bus.rsp_valid_o, bus.dp_abort_o, bus.busy_o}); end
    endtask

    task automatic test_reset_mid_wait();
        drive_req(3'b001, 32'h4, 32'h4, 5'd12);
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        checks++; if ({bus.busy_o, bus.rsp_valid_o, bus.dp_abort_o, bus.dp_start_o, bus.rsp_err_o, bus.req_ready_o} !== 6'b0) begin failures++; $display("[TB] FAIL rst_wait_flags got=%b exp=000000", {bus.busy_o, bus.rsp_valid_o, bus.dp_abort_o, bus.dp_start_o, bus.rsp_err_o, bus.req_ready_o}); end
        checks++; if ({bus.dp_op_o, bus.dp_a_o, bus.dp_b_o, bus.rsp_rd_o, bus.rsp_data_o} !== 104'd0) begin failures++; $display("[TB] FAIL rst_wait_regs got=%h exp=0", {bus.dp_op_o, bus.dp_a_o, bus.dp_b_o, bus.rsp_rd_o, bus.rsp_data_o}); end
        rst_i = 1'b0;
        tick();
        checks++; if ({bus.dp_abort_o, bus.rsp_valid_o, bus.busy_o} !== 3'b000) begin failures++; $display("[TB] FAIL rst_wait_silent got=%b exp=000", {bus.dp_abort_o, bus.rsp_valid_o, bus.busy_o}); end

        drive_req(3'b001, 32'h2, 32'h2, 5'd7);
        tick();
        bus.req_valid_i = 1'b0;
        checks++; if (bus.dp_start_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_recover_start got=%0b exp=1", bus.dp_start_o); end
        tick();
        tick();
        bus.dp_done_i   = 1'b1;
        bus.dp_result_i = 32'h4;
        tick();
        bus.dp_done_i = 1'b0;
        checks++; if ({bus.rsp_valid_o, bus.rsp_rd_o, bus.rsp_data_o, bus.rsp_err_o} !== {1'b1, 5'd7, 32'h4, 1'b0}) begin failures++; $display("[TB] FAIL rst_recover_rsp got=%h exp=%h", {bus.rsp_valid_o, bus.rsp_rd_o, bus.rsp_data_o, bus.rsp_err_o}, {1'b1, 5'd7, 32'h4, 1'b0}); end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive_req(3'b111, 32'h0, 32'h0, 5'd3);
        tick();
        drive_req(3'b010, 32'd10, 32'd20, 5'd8);
        bus.rsp_ready_i = 1'b1;
        #1;
        checks++; if ({bus.req_ready_o, bus.rsp_valid_o} !== 2'b01) begin failures++; $display("[TB] FAIL b2b_no_bypass got=%b exp=01", {bus.req_ready_o, bus.rsp_valid_o}); end
        tick();
        bus.rsp_ready_i = 1'b0;
        #1;
        checks++; if ({bus.busy_o, bus.rsp_valid_o, bus.req_ready_o} !== 3'b001) begin failures++; $display("[TB] FAIL b2b_idle got=%b exp=001", {bus.busy_o, bus.rsp_valid_o, bus.req_ready_o}); end
        tick();
        bus.req_valid_i = 1'b0;
        checks++; if ({bus.dp_start_o, bus.dp_op_o, bus.dp_a_o, bus.dp_b_o} !== {1'b1, 3'd2, 32'd10, 32'd20}) begin failures++; $display("[TB] FAIL b2b_start got=%h exp=%h", {bus.dp_start_o, bus.dp_op_o, bus.dp_a_o, bus.dp_b_o}, {1'b1, 3'd2, 32'd10, 32'd20}); end
        tick();
        bus.dp_done_i   = 1'b1;
        bus.dp_result_i = 32'd30;
        tick();
        bus.dp_done_i = 1'b0;
        checks++; if ({bus.rsp_valid_o, bus.rsp_rd_o, bus.rsp_data_o, bus.rsp_err_o} !== {1'b1, 5'd8, 32'd30, 1'b0}) begin failures++; $display("[TB] FAIL b2b_rsp got=%h exp=%h", {bus.rsp_valid_o, bus.rsp_rd_o, bus.rsp_data_o, bus.rsp_err_o}, {1'b1, 5'd8, 32'd30, 1'b0}); end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = 3'b000;
        bus.req_a_i     = 32'h0;
        bus.req_b_i     = 32'h0;
        bus.req_rd_i    = 5'd0;
        bus.dp_done_i   = 1'b0;
        bus.dp_result_i = 32'h0;
        bus.rsp_ready_i = 1'b0;
        bus.flush_i     = 1'b0;

        test_reset();
        test_normal();
        test_backpressure();
        test_timeout();
        test_done_at_limit();
        test_illegal();
        test_flush();
        test_reset_mid_wait();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
